// File: rtl/window_pkg.sv
// rtl/window_pkg.sv - shared defaults, counter width helper and window index helper
package window_pkg;

  localparam int DEF_K      = 11;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_COLS   = 640;
  localparam int DEF_ROWS   = 480;

  typedef struct packed {
    logic win_ready;
    logic line_end;
    logic frame_end;
  } pos_flags_t;

  function automatic int cnt_w_for(input int cols, input int rows);
    int m;
    m = (cols > rows) ? cols : rows;
    return $clog2(m + 1);
  endfunction

  // LSB of pixel(r,c) inside the packed window bus
  function automatic int pix_lsb(input int r, input int c, input int k, input int dw);
    return ((r * k) + c) * dw;
  endfunction

endpackage

// File: rtl/window_pos_counter.sv
// rtl/window_pos_counter.sv - column/row position of the stage-2 beat with line/frame detect
module window_pos_counter
  import window_pkg::*;
#(
  parameter int K     = DEF_K,
  parameter int COLS  = DEF_COLS,
  parameter int ROWS  = DEF_ROWS,
  parameter int CNT_W = cnt_w_for(COLS, ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof,
  input  logic             beat,
  output logic [CNT_W-1:0] col_cnt,
  output logic [CNT_W-1:0] row_cnt,
  output pos_flags_t       flags
);

  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(ROWS - K);
  localparam logic [CNT_W-1:0] COL_FIRST = CNT_W'(K - 1);

  logic col_wrap;
  logic row_wrap;

  assign col_wrap = (col_cnt == COL_LAST);
  assign row_wrap = (row_cnt == ROW_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (sof) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (beat) begin
      if (col_wrap) begin
        col_cnt <= '0;
        row_cnt <= row_wrap ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Flags describe the beat currently at stage 2, i.e. the current count values
  always_comb begin
    flags           = '0;
    flags.win_ready = (col_cnt >= COL_FIRST);
    flags.line_end  = col_wrap;
    flags.frame_end = col_wrap && row_wrap;
  end

endmodule

// File: rtl/window_buffer_kxk.sv
// rtl/window_buffer_kxk.sv - KxK sliding window generator with position and line/frame markers
module window_buffer_kxk
  import window_pkg::*;
#(
  parameter int K      = DEF_K,
  parameter int DATA_W = DEF_DATA_W,
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int CNT_W  = cnt_w_for(COLS, ROWS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sof_i,
  input  logic                  valid_i,
  input  logic [K*DATA_W-1:0]   col_i,
  output logic [K*K*DATA_W-1:0] win_o,
  output logic                  win_valid_o,
  output logic [CNT_W-1:0]      col_o,
  output logic [CNT_W-1:0]      row_o,
  output logic                  line_done_o,
  output logic                  frame_done_o
);

  logic [K*DATA_W-1:0] tap_q;
  logic                vld_q;
  logic                beat;
  logic                emit;
  logic [CNT_W-1:0]    col_cnt;
  logic [CNT_W-1:0]    row_cnt;
  pos_flags_t          flags;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap_q <= '0;
      vld_q <= 1'b0;
    end else begin
      tap_q <= col_i;
      vld_q <= valid_i;
    end
  end

  // sof drops the beat already in stage 2 so it cannot land in the new frame
  assign beat = vld_q & ~sof_i;
  assign emit = beat & flags.win_ready;

  window_pos_counter #(
    .K     (K),
    .COLS  (COLS),
    .ROWS  (ROWS),
    .CNT_W (CNT_W)
  ) u_pos (
    .clk     (clk),
    .rst     (rst),
    .sof     (sof_i),
    .beat    (beat),
    .col_cnt (col_cnt),
    .row_cnt (row_cnt),
    .flags   (flags)
  );

  for (genvar r = 0; r < K; r++) begin : g_row
    logic [K*DATA_W-1:0] row_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        row_q <= '0;
      end else if (beat) begin
        row_q <= {tap_q[r*DATA_W +: DATA_W], row_q[K*DATA_W-1:DATA_W]};
      end
    end

    assign win_o[pix_lsb(r, 0, K, DATA_W) +: K*DATA_W] = row_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid_o  <= 1'b0;
      line_done_o  <= 1'b0;
      frame_done_o <= 1'b0;
      col_o        <= '0;
      row_o        <= '0;
    end else begin
      win_valid_o  <= emit;
      line_done_o  <= emit & flags.line_end;
      frame_done_o <= emit & flags.frame_end;
      if (emit) begin
        col_o <= col_cnt;
        row_o <= row_cnt;
      end
    end
  end

endmodule

// File: tb/tb_window_buffer_kxk.sv
// tb/tb_window_buffer_kxk.sv - scoreboard bench for window_buffer_kxk at K=3, 8x5 frames
module tb_window_buffer_kxk;

  localparam int K    = 3;
  localparam int DW   = 8;
  localparam int COLS = 8;
  localparam int ROWS = 5;
  localparam int CW   = 4;
  localparam int WW   = K * K * DW;

  typedef struct {
    logic [WW-1:0] win;
    int            col;
    int            row;
    bit            line;
    bit            frame;
    int            cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            sof_i;
  logic            valid_i;
  logic [K*DW-1:0] col_i;
  logic [WW-1:0]   win_o;
  logic            win_valid_o;
  logic [CW-1:0]   col_o;
  logic [CW-1:0]   row_o;
  logic            line_done_o;
  logic            frame_done_o;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  bit   pushed_last = 1'b0;

  window_buffer_kxk #(
    .K      (K),
    .DATA_W (DW),
    .COLS   (COLS),
    .ROWS   (ROWS),
    .CNT_W  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sof_i        (sof_i),
    .valid_i      (valid_i),
    .col_i        (col_i),
    .win_o        (win_o),
    .win_valid_o  (win_valid_o),
    .col_o        (col_o),
    .row_o        (row_o),
    .line_done_o  (line_done_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [K*DW-1:0] col_of(input int y, input int x, input int base);
    logic [K*DW-1:0] v;
    for (int r = 0; r < K; r++) v[r*DW +: DW] = DW'(base + (y + r) * 16 + x);
    return v;
  endfunction

  function automatic logic [WW-1:0] win_of(input int y, input int x, input int base);
    logic [WW-1:0] w;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[((r * K) + c) * DW +: DW] = DW'(base + (y + r) * 16 + (x - (K - 1) + c));
    return w;
  endfunction

  task automatic idle();
    sof_i       = 1'b0;
    valid_i     = 1'b0;
    pushed_last = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drive_beat(input int y, input int x, input int base, input bit sof);
    exp_t e;
    if (sof && pushed_last) void'(sb.pop_back());
    sof_i       = sof;
    valid_i     = 1'b1;
    col_i       = col_of(y, x, base);
    pushed_last = 1'b0;
    if (x >= K - 1) begin
      e.win   = win_of(y, x, base);
      e.col   = x;
      e.row   = y;
      e.line  = (x == COLS - 1);
      e.frame = e.line && (y == ROWS - K);
      e.cyc   = cyc + 2;
      sb.push_back(e);
      pushed_last = 1'b1;
    end
    @(posedge clk); #1;
    sof_i   = 1'b0;
    valid_i = 1'b0;
  endtask

  // gap_mode: 0 gapless, 1 alternate valid/idle, 2 random idles
  task automatic run_frame(input int base, input bit sof, input int gap_mode, input int n_beats);
    int n = 0;
    for (int y = 0; y <= ROWS - K; y++) begin
      for (int x = 0; x < COLS; x++) begin
        if (n < n_beats) begin
          drive_beat(y, x, base, sof && (n == 0));
          n++;
          if (gap_mode == 1) idle();
          else if (gap_mode == 2 && $urandom_range(0, 2) == 0) idle();
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_win"},   win_o, '0);
    chk({tag, "_valid"}, win_valid_o, 1'b0);
    chk({tag, "_col"},   col_o, '0);
    chk({tag, "_row"},   row_o, '0);
    chk({tag, "_line"},  line_done_o, 1'b0);
    chk({tag, "_frame"}, frame_done_o, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (win_valid_o) begin
        if (sb.size() == 0) begin
          chk("spurious_win", win_valid_o, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("win",   win_o, e.win);
          chk("col",   col_o, e.col);
          chk("row",   row_o, e.row);
          chk("line",  line_done_o, e.line);
          chk("frame", frame_done_o, e.frame);
          chk("lat",   cyc, e.cyc);
        end
      end else begin
        chk("done_idle", {line_done_o, frame_done_o}, 2'b00);
      end
    end
  end

  localparam int FULL = (ROWS - K + 1) * COLS;

  initial begin
    rst     = 1'b1;
    sof_i   = 1'b0;
    valid_i = 1'b0;
    col_i   = '0;
    #3 rst = 1'b0;
    #2 chk_all_zero("rst0");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle();

    run_frame(8'h00, 1'b1, 0, FULL);
    run_frame(8'h40, 1'b0, 0, FULL);
    idle();
    run_frame(8'h00, 1'b1, 1, FULL);
    idle();

    run_frame(8'h10, 1'b1, 0, 5);
    run_frame(8'h80, 1'b1, 0, FULL);
    idle();

    run_frame(8'h30, 1'b1, 2, 12);
    rst = 1'b0;
    #1 chk_all_zero("rst_mid");
    sb.delete();
    pushed_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle();
    run_frame(8'h20, 1'b0, 2, FULL);

    for (int i = 0; i < 6; i++) idle();
    chk("sb_left", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
